// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions: FSM encoding, register zero,
// and the NOP/bubble values loaded by flushed pipeline registers.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } hcu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, holds at all-ones.
// Ports: clk, rst_n (async active-low), inc, count (W bits).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush/freeze control for the 5-stage pipeline, with a
// memory-wait timeout FSM and stall/flush performance counters.
// Inputs: ID/EX hazard operands, branch_taken_EX, MEM access status.
// Outputs: stage write enables, IF/ID and ID/EX flushes, mem_err,
// stall_count, flush_count.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             ID_uses_Rt,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             branch_taken_EX,
  input  logic             EX_MEM_MemAccess,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [16:0] TIMEOUT = 17'(MEM_TIMEOUT);

  hcu_state_e  state_q;
  logic [15:0] wait_cnt_q;
  logic        mem_err_q;

  logic busy;
  logic load_use;
  logic freeze;
  logic stall_inc;
  logic flush_inc;

  assign busy = EX_MEM_MemAccess && !mem_ready;

  assign load_use = ID_EX_MemRead
                 && (ID_EX_Rt != REG_ZERO)
                 && ((ID_EX_Rt == IF_ID_Rs)
                  || (ID_uses_Rt && (ID_EX_Rt == IF_ID_Rt)));

  // Holding everything during reset keeps the pipeline quiet
  // until the controller itself is out of reset.
  assign freeze = busy || (state_q == ERROR) || !rst_n;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    if (freeze) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
    end else if (branch_taken_EX) begin
      // The ID instruction is squashed, so a load-use on it is moot.
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (busy) begin
            wait_cnt_q <= 16'd1;
            if (MEM_TIMEOUT == 1) begin
              state_q   <= ERROR;
              mem_err_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!busy) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if ({1'b0, wait_cnt_q} + 17'd1 == TIMEOUT) begin
            state_q   <= ERROR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        ERROR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign mem_err = mem_err_q;

  assign stall_inc = freeze || (load_use && !branch_taken_EX);
  assign flush_inc = !freeze && branch_taken_EX;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: priority table plus
// memory-wait, timeout, reset and counter-saturation sequences.
module tb_hazard_control_unit;
  import hazard_control_unit_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       memread;
  logic [4:0] ex_rt;
  logic       br;
  logic       memacc;
  logic       ready;

  logic [6:0]  ctl1, ctl2, ctl3;
  logic        err1, err2, err3;
  logic [31:0] sc1, fc1, sc2, fc2;
  logic [2:0]  sc3, fc3;

  int checks;
  int failures;
  int exp_sc;
  int exp_fc;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] ex_rt;
    logic       br;
    logic       memacc;
    logic       ready;
    logic [6:0] ctl;
    int         s_inc;
    int         f_inc;
  } vec_t;

  vec_t vecs[8];

  localparam logic [6:0] C_RUN   = 7'b1111100;
  localparam logic [6:0] C_STALL = 7'b0011101;
  localparam logic [6:0] C_FLUSH = 7'b1111111;
  localparam logic [6:0] C_FRZ   = 7'b0000000;

  hazard_control_unit #(.MEM_TIMEOUT(16), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs(rs), .IF_ID_Rt(rt), .ID_uses_Rt(uses_rt),
    .ID_EX_MemRead(memread), .ID_EX_Rt(ex_rt),
    .branch_taken_EX(br), .EX_MEM_MemAccess(memacc),
    .mem_ready(ready),
    .PC_Write(ctl1[6]), .IF_ID_Write(ctl1[5]),
    .ID_EX_Write(ctl1[4]), .EX_MEM_Write(ctl1[3]),
    .MEM_WB_Write(ctl1[2]), .IF_ID_Flush(ctl1[1]),
    .ID_EX_Flush(ctl1[0]), .mem_err(err1),
    .stall_count(sc1), .flush_count(fc1)
  );

  hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs(rs), .IF_ID_Rt(rt), .ID_uses_Rt(uses_rt),
    .ID_EX_MemRead(memread), .ID_EX_Rt(ex_rt),
    .branch_taken_EX(br), .EX_MEM_MemAccess(memacc),
    .mem_ready(ready),
    .PC_Write(ctl2[6]), .IF_ID_Write(ctl2[5]),
    .ID_EX_Write(ctl2[4]), .EX_MEM_Write(ctl2[3]),
    .MEM_WB_Write(ctl2[2]), .IF_ID_Flush(ctl2[1]),
    .ID_EX_Flush(ctl2[0]), .mem_err(err2),
    .stall_count(sc2), .flush_count(fc2)
  );

  hazard_control_unit #(.MEM_TIMEOUT(16), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs(rs), .IF_ID_Rt(rt), .ID_uses_Rt(uses_rt),
    .ID_EX_MemRead(memread), .ID_EX_Rt(ex_rt),
    .branch_taken_EX(br), .EX_MEM_MemAccess(memacc),
    .mem_ready(ready),
    .PC_Write(ctl3[6]), .IF_ID_Write(ctl3[5]),
    .ID_EX_Write(ctl3[4]), .EX_MEM_Write(ctl3[3]),
    .MEM_WB_Write(ctl3[2]), .IF_ID_Flush(ctl3[1]),
    .ID_EX_Flush(ctl3[0]), .mem_err(err3),
    .stall_count(sc3), .flush_count(fc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rs = 5'd0; rt = 5'd0; uses_rt = 1'b0;
    memread = 1'b0; ex_rt = 5'd0; br = 1'b0;
    memacc = 1'b0; ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_sc = 0;
    exp_fc = 0;
  endtask

  function automatic vec_t mk(input logic [4:0] a_rs,
                              input logic [4:0] a_rt,
                              input logic a_u, input logic a_mr,
                              input logic [4:0] a_ert,
                              input logic a_br, input logic a_ma,
                              input logic a_rdy,
                              input logic [6:0] a_ctl,
                              input int a_s, input int a_f);
    vec_t v;
    v.rs = a_rs; v.rt = a_rt; v.uses_rt = a_u;
    v.memread = a_mr; v.ex_rt = a_ert; v.br = a_br;
    v.memacc = a_ma; v.ready = a_rdy; v.ctl = a_ctl;
    v.s_inc = a_s; v.f_inc = a_f;
    return v;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    exp_sc = 0;
    exp_fc = 0;
    //         rs  rt  u  mr ert br ma rdy ctl     s  f
    vecs[0] = mk(8, 0, 0, 1, 8, 0, 0, 0, C_STALL, 1, 0);
    vecs[1] = mk(0, 0, 0, 1, 0, 0, 0, 0, C_RUN,   0, 0);
    vecs[2] = mk(3, 8, 0, 1, 8, 0, 0, 0, C_RUN,   0, 0);
    vecs[3] = mk(3, 8, 1, 1, 8, 0, 0, 0, C_STALL, 1, 0);
    vecs[4] = mk(8, 0, 0, 1, 8, 1, 0, 0, C_FLUSH, 0, 1);
    vecs[5] = mk(2, 4, 1, 0, 0, 1, 0, 0, C_FLUSH, 0, 1);
    vecs[6] = mk(1, 2, 1, 0, 0, 0, 1, 1, C_RUN,   0, 0);
    vecs[7] = mk(8, 8, 1, 0, 8, 0, 0, 0, C_RUN,   0, 0);

    // Reset state, with a branch pending to show it is ignored.
    idle();
    br = 1'b1;
    rst_n = 1'b0;
    #3;
    check("rst_ctl1", 32'(ctl1), 32'(C_FRZ));
    check("rst_ctl3", 32'(ctl3), 32'(C_FRZ));
    check("rst_sc1", sc1, 32'd0);
    check("rst_fc1", fc1, 32'd0);
    check("rst_err1", 32'(err1), 32'd0);
    check("rst_err3", 32'(err3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rs = vecs[i].rs; rt = vecs[i].rt;
      uses_rt = vecs[i].uses_rt; memread = vecs[i].memread;
      ex_rt = vecs[i].ex_rt; br = vecs[i].br;
      memacc = vecs[i].memacc; ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_ctl", i), 32'(ctl1),
            32'(vecs[i].ctl));
      @(posedge clk);
      #1;
      exp_sc += vecs[i].s_inc;
      exp_fc += vecs[i].f_inc;
      check($sformatf("vec%0d_sc", i), sc1, 32'(exp_sc));
      check($sformatf("vec%0d_fc", i), fc1, 32'(exp_fc));
    end

    // Memory wait of 3 cycles with a branch held in EX.
    do_reset();
    @(negedge clk);
    br = 1'b1; memacc = 1'b1; ready = 1'b0;
    memread = 1'b1; ex_rt = 5'd8; rs = 5'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("wait%0d_ctl", i), 32'(ctl1),
            32'(C_FRZ));
      @(negedge clk);
    end
    ready = 1'b1;
    #1;
    check("wait_flush_ctl", 32'(ctl1), 32'(C_FLUSH));
    @(posedge clk);
    #1;
    check("wait_sc", sc1, 32'd3);
    check("wait_fc", fc1, 32'd1);
    check("wait_state", 32'(dut1.state_q), 32'(RUN));
    check("wait_err", 32'(err1), 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("wait_after_ctl", 32'(ctl1), 32'(C_RUN));
    @(posedge clk);
    #1;
    check("wait_fc_once", fc1, 32'd1);

    // Timeout with MEM_TIMEOUT=4 on dut2.
    do_reset();
    @(negedge clk);
    memacc = 1'b1; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("to_err_early", 32'(err2), 32'd0);
    @(posedge clk);
    #1;
    check("to_err_set", 32'(err2), 32'd1);
    check("to_err1_clear", 32'(err1), 32'd0);
    @(negedge clk);
    ready = 1'b1;
    #1;
    check("to_frozen", 32'(ctl2), 32'(C_FRZ));
    check("to_dut1_run", 32'(ctl1), 32'(C_RUN));
    @(posedge clk);
    #1;
    check("to_err_sticky", 32'(err2), 32'd1);
    check("to_sc2", sc2, 32'd5);
    check("to_fc2", fc2, 32'd0);
    rst_n = 1'b0;
    #1;
    check("to_rst_err", 32'(err2), 32'd0);
    check("to_rst_sc", sc2, 32'd0);
    check("to_rst_state", 32'(dut2.state_q), 32'(RUN));
    check("to_rst_ctl", 32'(ctl2), 32'(C_FRZ));
    @(negedge clk);
    rst_n = 1'b1;
    memacc = 1'b0;
    #1;
    check("to_rel_ctl", 32'(ctl2), 32'(C_RUN));
    @(posedge clk);
    #1;
    check("to_rel_err", 32'(err2), 32'd0);

    // Saturation of a 3-bit stall counter.
    do_reset();
    @(negedge clk);
    memread = 1'b1; ex_rt = 5'd8; rs = 5'd8;
    repeat (10) @(posedge clk);
    #1;
    check("sat_sc3", 32'(sc3), 32'd7);
    check("sat_fc3", 32'(fc3), 32'd0);
    check("sat_sc1", sc1, 32'd10);
    @(negedge clk);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
